// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequence transmitter.
package fib_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} fib_state_t;

    localparam int F0 = 0;
    localparam int F1 = 1;

endpackage

// File: rtl/fib_seq_gen_pace_counter.sv
// Loadable down-counter that times the idle gap between emitted terms.
module pace_counter #(
    parameter int PACE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic zero
);

    localparam int CW = (PACE > 1) ? $clog2(PACE) : 1;

    logic [CW-1:0] cnt;

    // Loaded with PACE-1 so that counting down to zero spans exactly PACE cycles.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(PACE - 1);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term transmitter: emits F0,F1,... over valid/ready while terms fit in WIDTH bits.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = 6,
    parameter int PACE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             loop_en,
    input  logic             stop,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    fib_state_t       state, state_nxt;
    logic [WIDTH-1:0] a;
    logic [WIDTH:0]   b;
    logic [IDX_W-1:0] idx;
    logic             loop_q;
    logic             xfer;
    logic             last;
    logic             pace_zero;

    assign xfer = (state == SEND) && out_ready;
    // b carries one extra bit: once the successor overflows WIDTH, a is the last term.
    assign last = b[WIDTH];

    generate
        if (PACE > 0) begin : g_pace
            pace_counter #(.PACE(PACE)) u_pace (
                .clk   (clk),
                .reset (reset),
                .load  (xfer),
                .zero  (pace_zero)
            );
        end else begin : g_nopace
            assign pace_zero = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = SEND;
                SEND: if (xfer) begin
                    if (last && !loop_q) state_nxt = DONE;
                    else                 state_nxt = (PACE > 0) ? GAP : SEND;
                end
                GAP:  if (pace_zero) state_nxt = SEND;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A transfer coinciding with stop still advances; the next start reloads anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= WIDTH'(F0);
            b      <= (WIDTH+1)'(F1);
            idx    <= '0;
            loop_q <= 1'b0;
        end else if (state == IDLE && start && !stop) begin
            a      <= WIDTH'(F0);
            b      <= (WIDTH+1)'(F1);
            idx    <= '0;
            loop_q <= loop_en;
        end else if (xfer) begin
            if (!last) begin
                a   <= b[WIDTH-1:0];
                b   <= {1'b0, a} + b;
                idx <= idx + IDX_W'(1);
            end else if (loop_q) begin
                a   <= WIDTH'(F0);
                b   <= (WIDTH+1)'(F1);
                idx <= '0;
            end
        end
    end

    always_comb begin
        out_valid = (state == SEND);
        out_value = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_value = a;
            out_index = idx;
            out_last  = last;
        end
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: scoreboard of expected terms, immediate-assertion checks.
module tb_fib_seq_gen;

    typedef struct {
        logic [3:0] v;
        logic [5:0] i;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, start, loop_en, stop, out_ready;
    logic       v0_valid, v0_last, v0_busy, v0_done;
    logic [3:0] v0_value;
    logic [5:0] v0_index;
    logic       v1_valid, v1_last, v1_busy, v1_done;
    logic [3:0] v1_value;
    logic [5:0] v1_index;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    int   fib_tab[8] = '{0, 1, 1, 2, 3, 5, 8, 13};

    always #5 clk = ~clk;

    fib_seq_gen #(.WIDTH(4), .IDX_W(6), .PACE(0)) u0 (
        .clk(clk), .reset(reset), .start(start), .loop_en(loop_en), .stop(stop),
        .out_ready(out_ready), .out_valid(v0_valid), .out_value(v0_value),
        .out_index(v0_index), .out_last(v0_last), .busy(v0_busy), .done(v0_done)
    );

    fib_seq_gen #(.WIDTH(4), .IDX_W(6), .PACE(2)) u1 (
        .clk(clk), .reset(reset), .start(start), .loop_en(loop_en), .stop(stop),
        .out_ready(out_ready), .out_valid(v1_valid), .out_value(v1_value),
        .out_index(v1_index), .out_last(v1_last), .busy(v1_busy), .done(v1_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_run();
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.v = 4'(fib_tab[i]);
            e.i = 6'(i);
            e.l = (i == 7);
            q.push_back(e);
        end
    endtask

    // Called when a transfer is about to happen on the next posedge.
    task automatic sb_check();
        exp_t e;
        if (q.size() == 0) begin
            chk("sb_underflow", 32'(q.size()), 1);
        end else begin
            e = q.pop_front();
            chk("sb_value", 32'(v0_value), 32'(e.v));
            chk("sb_index", 32'(v0_index), 32'(e.i));
            chk("sb_last",  32'(v0_last),  32'(e.l));
        end
    endtask

    task automatic run_to_done(input int hold_idx, input int hold_n, input int budget);
        int held = 0;
        int seen = 0;
        for (int c = 0; c < budget; c++) begin
            if (v0_done) begin
                seen = 1;
                break;
            end
            if (v0_valid && 32'(v0_index) == hold_idx && held < hold_n) begin
                out_ready = 1'b0;
                held++;
                chk("hold_value", 32'(v0_value), 2);
                chk("hold_index", 32'(v0_index), 3);
                chk("hold_valid", 32'(v0_valid), 1);
            end else begin
                out_ready = 1'b1;
                if (v0_valid) sb_check();
            end
            step();
        end
        chk("done_seen", 32'(seen), 1);
        chk("held_cycles", 32'(held), (hold_idx < 0) ? 0 : 32'(hold_n));
        chk("sb_empty", 32'(q.size()), 0);
        step();
        chk("idle_busy", 32'(v0_busy), 0);
        chk("idle_done", 32'(v0_done), 0);
    endtask

    initial begin
        int found;
        reset = 1'b1; start = 1'b0; loop_en = 1'b0; stop = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_valid", 32'(v0_valid), 0);
        chk("rst_value", 32'(v0_value), 0);
        chk("rst_index", 32'(v0_index), 0);
        chk("rst_last",  32'(v0_last),  0);
        chk("rst_busy",  32'(v0_busy),  0);
        chk("rst_done",  32'(v0_done),  0);
        reset = 1'b0;
        step();

        // Back-to-back single run: 8 consecutive terms, then done, then idle.
        push_run();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("b2b_valid", 32'(v0_valid), 1);
            chk("b2b_done",  32'(v0_done), 0);
            sb_check();
            step();
        end
        chk("b2b_done_pulse", 32'(v0_done), 1);
        chk("b2b_done_valid", 32'(v0_valid), 0);
        chk("b2b_done_busy",  32'(v0_busy), 1);
        step();
        chk("b2b_idle_busy", 32'(v0_busy), 0);
        chk("b2b_idle_done", 32'(v0_done), 0);

        // Backpressure: hold 3 cycles on value 2 (index 3).
        push_run();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(3, 3, 40);

        // Loop mode: wraps to F0 after 13, no done, stop ends it.
        push_run();
        push_run();
        void'(q.pop_back()); void'(q.pop_back()); void'(q.pop_back()); void'(q.pop_back());
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        loop_en = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("loop_valid", 32'(v0_valid), 1);
            chk("loop_done",  32'(v0_done), 0);
            if (k == 11) stop = 1'b1;
            sb_check();
            step();
        end
        stop = 1'b0;
        chk("loop_stop_valid", 32'(v0_valid), 0);
        chk("loop_stop_busy",  32'(v0_busy), 0);
        chk("loop_stop_done",  32'(v0_done), 0);
        chk("loop_sb_empty",   32'(q.size()), 0);

        // Stop while value 5 is stalled.
        push_run();
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (v0_valid && v0_value == 4'd5) begin
                out_ready = 1'b0;
                stop = 1'b1;
                found = 1;
                break;
            end
            if (v0_valid) sb_check();
            step();
        end
        chk("stop_found5", 32'(found), 1);
        step();
        stop = 1'b0;
        out_ready = 1'b1;
        chk("stop_valid", 32'(v0_valid), 0);
        chk("stop_busy",  32'(v0_busy), 0);
        chk("stop_done",  32'(v0_done), 0);
        q.delete();
        step();
        chk("stop_no_done", 32'(v0_done), 0);
        push_run();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_first_valid", 32'(v0_valid), 1);
        chk("restart_first_value", 32'(v0_value), 0);
        run_to_done(-1, 0, 30);

        // Paced instance: valid 1,0,0,... and 13 at cycle 22 after start.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            chk("pace_valid", 32'(v1_valid), ((k - 1) % 3 == 0) ? 1 : 0);
            if (k == 22) begin
                chk("pace_13_value", 32'(v1_value), 13);
                chk("pace_13_last",  32'(v1_last), 1);
                chk("pace_13_index", 32'(v1_index), 7);
            end
            if (k < 22) step();
        end
        step();
        chk("pace_done", 32'(v1_done), 1);
        step(); step();

        // Reset mid-sequence at index 4, then start & stop together in IDLE.
        push_run();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (v0_valid && v0_index == 6'd4) begin
                found = 1;
                break;
            end
            if (v0_valid) sb_check();
            step();
        end
        chk("rst_mid_found4", 32'(found), 1);
        reset = 1'b1;
        step();
        chk("rst_mid_valid", 32'(v0_valid), 0);
        chk("rst_mid_value", 32'(v0_value), 0);
        chk("rst_mid_index", 32'(v0_index), 0);
        chk("rst_mid_busy",  32'(v0_busy), 0);
        chk("rst_mid_done",  32'(v0_done), 0);
        reset = 1'b0;
        q.delete();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_valid", 32'(v0_valid), 0);
        chk("startstop_busy",  32'(v0_busy), 0);
        step();
        chk("startstop_still_idle", 32'(v0_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
